debug_dr_engine: RTL
====================

DEBUG_DR_ENGINE -- requirements
Module: debug_dr_engine

Interface
REQ-001 The block SHALL take parameter DR_W, default 38, as the data-register (scan chain) width in bits, legal range 8..64.
REQ-002 The block SHALL take parameter IR_W, default 2, as the instruction width; NCH = 2**IR_W is the channel count.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port ir_in, input, IR_W, instruction value presented with uir.
REQ-006 The block SHALL have port uir, input, 1, single-cycle update-IR strobe.
REQ-007 The block SHALL have port cdr, input, 1, single-cycle capture-DR strobe.
REQ-008 The block SHALL have port sdr, input, 1, shift-DR enable, one bit per asserted cycle.
REQ-009 The block SHALL have port udr, input, 1, single-cycle update-DR strobe.
REQ-010 The block SHALL have port tdi, input, 1, serial data in.
REQ-011 The block SHALL have port capture_data, input, NCH*DR_W, per-channel capture words, channel k at bits [k*DR_W +: DR_W].
REQ-012 The block SHALL have port tdo, output, 1, serial data out, equal to sr[0].
REQ-013 The block SHALL have port jdo, output, DR_W, last accepted update word.
REQ-014 The block SHALL have port take_action, output, NCH, one-hot single-cycle action pulse.
REQ-015 The block SHALL have port take_no_action, output, NCH, one-hot single-cycle no-action pulse.
REQ-016 The block SHALL have port busy, output, 1, high while a scan is in progress (capture seen, update pending).
REQ-017 The block SHALL have port scan_err, output, 1, sticky short/long-scan flag.
REQ-018 The block SHALL have port parity_err, output, 1, single-cycle parity-fail pulse.

Function
REQ-019 On uir, the block SHALL register ir_in into ir_q. A udr in the same cycle SHALL use the old ir_q.
REQ-020 On cdr, the block SHALL load sr with channel ir_q of capture_data, clear the shift counter, and set busy.
REQ-021 On sdr without cdr or udr, the block SHALL shift sr right, with tdi entering sr[DR_W-1] and sr[0] leaving on tdo.
REQ-022 The shift counter SHALL increment per shift and saturate at DR_W+1.
REQ-023 Strobe priority in one cycle SHALL be cdr > udr > sdr; the lower strobes are ignored that cycle.
REQ-024 On udr with busy=1 and counter == DR_W, the block SHALL accept the update: jdo <= sr, busy <= 0.
REQ-025 One cycle after an accepted update, the block SHALL pulse take_action[ir_q] if sr[DR_W-1]=1, else take_no_action[ir_q], for exactly one cycle.
REQ-026 On udr with counter != DR_W, the block SHALL leave jdo unchanged, emit no pulse, set scan_err, and clear busy.
REQ-027 udr with busy=0 SHALL be ignored entirely.
REQ-028 scan_err SHALL clear only on reset or on the next cdr.
REQ-029 At most one bit of take_action|take_no_action SHALL be high in any cycle.

Reset
REQ-030 Reset SHALL force sr, jdo, ir_q and the counter to 0, and force busy, scan_err, parity_err and all pulse outputs to 0 on the next edge; tdo then reads 0.
REQ-031 Reset asserted mid-scan SHALL abort the scan: no pulse, and jdo stays 0.
REQ-032 Any pulse scheduled for the cycle after reset SHALL be suppressed.

Configuration
REQ-033 With macro DEBUG_DR_PARITY_EN defined, an update that REQ-024 would accept SHALL also require even parity over all DR_W bits of sr.
REQ-034 With DEBUG_DR_PARITY_EN defined, an update with odd parity SHALL leave jdo unchanged, emit no action pulse, pulse parity_err for one cycle, and clear busy.
REQ-035 Without DEBUG_DR_PARITY_EN, parity_err SHALL be tied to 0 and no parity logic SHALL be built.

Verification
REQ-036 Bench SHALL cover: uir ir_in=2; cdr; 38 sdr with tdi bits forming 38'h20_0000_0001; udr -> jdo=38'h20_0000_0001, take_action=4'b0100 one cycle after udr, single cycle.
REQ-037 Bench SHALL cover: ir=1, capture_data ch1 = 38'h15_5555_5555; cdr; 38 sdr -> tdo emits 1,0,1,0... (LSB first); MSB=0 word on udr -> take_no_action=4'b0010.
REQ-038 Bench SHALL cover: cdr; 37 sdr; udr -> scan_err=1, busy=0, jdo unchanged, no pulses; next cdr clears scan_err.
REQ-039 Bench SHALL cover: cdr and udr in the same cycle -> capture only, busy=1; uir ir_in=3 with udr in the same cycle -> pulse on the old ir_q channel.
REQ-040 Bench SHALL cover: reset asserted after 20 of 38 shifts -> busy=0, jdo=0, no pulse; a following full scan behaves as in REQ-036.
REQ-041 Bench SHALL cover, with DEBUG_DR_PARITY_EN: full scan of odd-parity word 38'h00_0000_0001 -> parity_err one-cycle pulse, no action, jdo unchanged.

Source files
------------

// File: rtl/debug_dr_engine.sv
`default_nettype none
// ============================================================================
//  Module      : debug_dr_engine
//  Description : Debug data-register scan engine. Captures a per-channel word
//                into a shift register, shifts it out LSB-first on tdo while
//                shifting tdi in at the MSB, and on update either accepts the
//                word (jdo plus a one-hot action / no-action pulse on the
//                selected channel) or flags a short/long scan.
//                Optional feature macro: DEBUG_DR_PARITY_EN adds an
//                even-parity requirement on accepted updates and drives
//                parity_err; without it parity_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_dr_engine #(
    parameter int DR_W = 38,
    parameter int IR_W = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [IR_W-1:0]              ir_in,
    input  logic                         uir,
    input  logic                         cdr,
    input  logic                         sdr,
    input  logic                         udr,
    input  logic                         tdi,
    input  logic [(2**IR_W)*DR_W-1:0]    capture_data,
    output logic                         tdo,
    output logic [DR_W-1:0]              jdo,
    output logic [(2**IR_W)-1:0]         take_action,
    output logic [(2**IR_W)-1:0]         take_no_action,
    output logic                         busy,
    output logic                         scan_err,
    output logic                         parity_err
);

    localparam int NCH   = 2**IR_W;
    localparam int CNT_W = $clog2(DR_W + 2);

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DR_W);
    localparam logic [CNT_W-1:0] c_cnt_sat  = CNT_W'(DR_W + 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [NCH-1:0]   c_ch0_hot  = NCH'(1);

    logic [IR_W-1:0]  r_ir_q;
    logic [DR_W-1:0]  r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [DR_W-1:0]  r_jdo;
    logic             r_scan_err;
    logic [NCH-1:0]   r_take_action;
    logic [NCH-1:0]   r_take_no_action;

    logic [DR_W-1:0]  w_ch [NCH];
    logic [DR_W-1:0]  w_cap_word;
    logic [NCH-1:0]   w_onehot;
    logic             w_upd;
    logic             w_cnt_ok;
    logic             w_parity_ok;
    logic             w_accept;
    logic             w_bad_len;
    logic             w_shift;

    // Split the flat capture bus into one word per channel
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign w_ch[k] = capture_data[k*DR_W +: DR_W];
    end

    assign w_cap_word = w_ch[r_ir_q];
    assign w_onehot   = c_ch0_hot << r_ir_q;

    // Strobe decode: capture outranks update, update outranks shift
    assign w_upd     = udr & ~cdr & r_busy;
    assign w_shift   = sdr & ~cdr & ~udr;
    assign w_cnt_ok  = (r_cnt == c_cnt_full);
    assign w_bad_len = w_upd & ~w_cnt_ok;
    assign w_accept  = w_upd & w_cnt_ok & w_parity_ok;

`ifdef DEBUG_DR_PARITY_EN
    logic r_parity_err;

    // Even parity over the whole scanned word is required to accept it
    assign w_parity_ok = ~^r_sr;

    // One-cycle pulse when a correctly sized update fails parity
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_upd & w_cnt_ok & ~w_parity_ok;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign w_parity_ok = 1'b1;
    assign parity_err  = 1'b0;
`endif

    // Instruction register; an update in the same cycle still sees the old value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_q <= '0;
        end else if (uir) begin
            r_ir_q <= ir_in;
        end
    end

    // Shift register and saturating shift counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (cdr) begin
            r_sr  <= w_cap_word;
            r_cnt <= '0;
        end else if (w_shift) begin
            r_sr <= {tdi, r_sr[DR_W-1:1]};
            if (r_cnt != c_cnt_sat) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    // Busy spans capture to the next update seen while busy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else if (cdr) begin
            r_busy <= 1'b1;
        end else if (w_upd) begin
            r_busy <= 1'b0;
        end
    end

    // Update word holds the last accepted scan
    always_ff @(posedge clk) begin
        if (reset) begin
            r_jdo <= '0;
        end else if (w_accept) begin
            r_jdo <= r_sr;
        end
    end

    // Sticky scan-length error, cleared by the next capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_err <= 1'b0;
        end else if (cdr) begin
            r_scan_err <= 1'b0;
        end else if (w_bad_len) begin
            r_scan_err <= 1'b1;
        end
    end

    // Single-cycle one-hot action pulse chosen by the word MSB
    always_ff @(posedge clk) begin
        if (reset) begin
            r_take_action    <= '0;
            r_take_no_action <= '0;
        end else begin
            r_take_action    <= '0;
            r_take_no_action <= '0;
            if (w_accept) begin
                if (r_sr[DR_W-1]) begin
                    r_take_action <= w_onehot;
                end else begin
                    r_take_no_action <= w_onehot;
                end
            end
        end
    end

    assign tdo            = r_sr[0];
    assign jdo            = r_jdo;
    assign busy           = r_busy;
    assign scan_err       = r_scan_err;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;

endmodule
`default_nettype wire
